fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 8-bit processor, directly upstream of the control decoder. Holds the program counter, addresses the instruction ROM, and presents the fetched instruction byte to the decoder each cycle. Consumes the decoder's `branchf`, `branchb` and `done` outputs and a branch offset from the register file to compute the next PC. A small run/halt state machine starts execution on command and freezes the machine on halt.

## Interface
- `PC_WIDTH`, 10: program counter / ROM address width.
- `OFFSET_WIDTH`, 8: branch offset width; zero-extended to `PC_WIDTH`.
- `COUNT_WIDTH`, 16: executed-instruction counter width.
- `HALT_INSTR`, 8'h88: byte driven to the decoder when not running. This is the halt encoding, so it causes no register, CB or memory writes.

- `clk_i` input 1: single clock; all state updates on the rising edge.
- `reset_n_i` input 1: reset, synchronous, active-low.
- `start_i` input 1: start request; honoured in IDLE and HALT only.
- `start_addr_i` input PC_WIDTH: PC loaded when start is honoured.
- `instr_rdata_i` input 8: ROM read data, combinational from `pc_o`.
- `branchf_i` input 1: forward branch taken (from decoder).
- `branchb_i` input 1: backward branch taken (from decoder).
- `done_i` input 1: halt decoded (from decoder).
- `branch_offset_i` input OFFSET_WIDTH: branch distance, the rs register value.
- `pc_o` output PC_WIDTH: ROM address, driven directly by the PC register.
- `instruction_o` output 8: byte to the decoder.
- `running_o` output 1: high in RUN; the datapath gates its writes with it.
- `halted_o` output 1: high in HALT.
- `instr_count_o` output COUNT_WIDTH: number of instructions executed since the last start.

## Operation
States: IDLE, RUN, HALT.
- **IDLE**
  - `instruction_o` = `HALT_INSTR`.
  - Decoder inputs (`done_i`, `branchf_i`, `branchb_i`) are ignored.
  - `start_i` = 1: PC ← `start_addr_i`, count ← 0, go to RUN.
- **RUN**
  - `instruction_o` = `instr_rdata_i`.
  - Next PC, in priority order:
    1. `done_i`: PC holds, go to HALT.
    2. `branchf_i`: PC ← PC + zext(offset).
    3. `branchb_i`: PC ← PC − zext(offset).
    4. Otherwise: PC ← PC + 1.
  - `branchf_i` and `branchb_i` both high: forward wins.
  - `done_i` overrides both branches.
  - `start_i` is ignored.
- **HALT**
  - `instruction_o` = `HALT_INSTR`.
  - PC and count are frozen.
  - `start_i` = 1: PC ← `start_addr_i`, count ← 0, go to RUN (restart).
- **Arithmetic**
  - All PC math is modulo 2^PC_WIDTH: wraps silently in both directions.
  - Offset 0 on a taken branch leaves PC unchanged; it re-executes the same instruction and is not an error.
- **Counter**
  - Increments by 1 on every RUN cycle, including the cycle in which `done_i` is seen.
  - Saturates at all-ones; no wrap.

## Timing
- **Reset** (`reset_n_i` = 0 at a rising edge): state IDLE, PC 0, count 0.
  - Resulting outputs: `pc_o` 0, `instruction_o` `HALT_INSTR`, `running_o` 0, `halted_o` 0, `instr_count_o` 0.
  - Reset mid-RUN or mid-HALT has the same effect and overrides `start_i`.
- **Outputs**: `pc_o`, `running_o`, `halted_o` and `instr_count_o` are registered. `instruction_o` is combinational from state and `instr_rdata_i`.
- **Start latency**: `start_i` sampled at edge N gives `running_o` = 1 and `pc_o` = `start_addr_i` after edge N. The first instruction is decoded in cycle N+1.
- **Throughput**: one instruction per cycle. The PC update from a branch or halt takes effect at the next edge; no delay slot, no bubble.
- **Halt latency**: `done_i` high in RUN cycle K gives `halted_o` = 1 and `running_o` = 0 from edge K+1. `pc_o` stays at the halt instruction's address.

## Test plan
1. **Reset and start.** Reset, then `start_i` pulse with `start_addr_i` = 0x010 and ROM holding non-branch bytes. Required: `pc_o` reads 0x010, 0x011, 0x012 on successive cycles; `instr_count_o` reads 1, 2, 3.
2. **Forward and backward branch.** At PC 0x020, `branchf_i` = 1 with offset 5: next PC 0x025. At 0x025, `branchb_i` = 1 with offset 0x0A: next PC 0x01B. Both branch inputs high at 0x01B with offset 2: next PC 0x01D.
3. **Wrap-around.** Start at 0x3FF: next PC 0x000. At 0x002, `branchb_i` with offset 4: next PC 0x3FE.
4. **Halt then restart.** `done_i` high together with `branchf_i` at PC 0x030 after 7 instructions. Required: `halted_o` = 1, `pc_o` = 0x030, count 8, `instruction_o` = 0x88 and all frozen for 10 cycles. Then `start_i` with address 0x100: count resets, `pc_o` = 0x100.
5. **Ignored inputs and mid-run reset.** `done_i` and `branchf_i` asserted in IDLE: no state change. `start_i` held high in RUN: PC continues sequentially. `reset_n_i` low at PC 0x050: all outputs return to reset values on the next edge.
6. **Counter saturation.** Use `COUNT_WIDTH` = 4 and run 20 instructions. Required: `instr_count_o` stops at 0xF.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, ROM addressing and the run/halt
// control machine that gates the datapath of the 8-bit processor.
module fetch_unit #(
    parameter int           PC_WIDTH     = 10,
    parameter int           OFFSET_WIDTH = 8,
    parameter int           COUNT_WIDTH  = 16,
    parameter logic [7:0]   HALT_INSTR   = 8'h88
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    input  logic [PC_WIDTH-1:0]     start_addr_i,
    input  logic [7:0]              instr_rdata_i,
    input  logic                    branchf_i,
    input  logic                    branchb_i,
    input  logic                    done_i,
    input  logic [OFFSET_WIDTH-1:0] branch_offset_i,
    output logic [PC_WIDTH-1:0]     pc_o,
    output logic [7:0]              instruction_o,
    output logic                    running_o,
    output logic                    halted_o,
    output logic [COUNT_WIDTH-1:0]  instr_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [PC_WIDTH-1:0]     pc_q;
    logic [PC_WIDTH-1:0]     pc_d;
    logic [PC_WIDTH-1:0]     offset_ext_s;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [COUNT_WIDTH-1:0]  count_d;
    logic                    running_q;
    logic                    halted_q;

    assign offset_ext_s = {{(PC_WIDTH-OFFSET_WIDTH){1'b0}}, branch_offset_i};

    // State, PC and counter registers; status flags follow the next state so they stay registered
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            pc_q      <= {PC_WIDTH{1'b0}};
            count_q   <= {COUNT_WIDTH{1'b0}};
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            running_q <= (state_d == ST_RUN);
            halted_q  <= (state_d == ST_HALT);
        end
    end

    // Next-state logic: done beats any branch, start only matters outside RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
                else         state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (done_i) state_d = ST_HALT;
                else        state_d = ST_RUN;
            end
            ST_HALT: begin
                if (start_i) state_d = ST_RUN;
                else         state_d = ST_HALT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // PC and counter update; PC arithmetic wraps modulo 2^PC_WIDTH, counter saturates
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            ST_RUN: begin
                if (&count_q) count_d = count_q;
                else          count_d = count_q + COUNT_WIDTH'(1);
                if (done_i)         pc_d = pc_q;
                else if (branchf_i) pc_d = pc_q + offset_ext_s;
                else if (branchb_i) pc_d = pc_q - offset_ext_s;
                else                pc_d = pc_q + PC_WIDTH'(1);
            end
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    pc_d    = start_addr_i;
                    count_d = {COUNT_WIDTH{1'b0}};
                end else begin
                    pc_d    = pc_q;
                    count_d = count_q;
                end
            end
            default: begin
                pc_d    = {PC_WIDTH{1'b0}};
                count_d = {COUNT_WIDTH{1'b0}};
            end
        endcase
    end

    // Decoder sees the halt encoding whenever the machine is not running
    always_comb begin
        instruction_o = HALT_INSTR;
        case (state_q)
            ST_RUN:  instruction_o = instr_rdata_i;
            default: instruction_o = HALT_INSTR;
        endcase
    end

    assign pc_o          = pc_q;
    assign running_o     = running_q;
    assign halted_o      = halted_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-level reference model plus a handful
// of hand-computed checkpoints from the test plan.
module tb_fetch_unit;

    localparam int CW = 4;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [9:0]     start_addr;
    logic [7:0]     instr_rdata;
    logic           branchf;
    logic           branchb;
    logic           done;
    logic [7:0]     offset;
    logic [9:0]     pc;
    logic [7:0]     instruction;
    logic           running;
    logic           halted;
    logic [CW-1:0]  count;

    logic [7:0] rom [1024];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // model: 0 idle, 1 run, 2 halt
    int m_state = 0;
    int m_pc    = 0;
    int m_cnt   = 0;

    fetch_unit #(
        .PC_WIDTH(10), .OFFSET_WIDTH(8), .COUNT_WIDTH(CW), .HALT_INSTR(8'h88)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .start_addr_i(start_addr),
        .instr_rdata_i(instr_rdata), .branchf_i(branchf), .branchb_i(branchb),
        .done_i(done), .branch_offset_i(offset), .pc_o(pc), .instruction_o(instruction),
        .running_o(running), .halted_o(halted), .instr_count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr_rdata = rom[pc];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advanced on each rising edge from the sampled inputs
    always @(posedge clk) begin
        if (!reset_n) begin
            m_state <= 0; m_pc <= 0; m_cnt <= 0;
        end else if (m_state == 1) begin
            m_cnt <= (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
            if (done)         m_state <= 2;
            else if (branchf) m_pc <= (m_pc + offset) % 1024;
            else if (branchb) m_pc <= (m_pc - offset + 1024) % 1024;
            else              m_pc <= (m_pc + 1) % 1024;
        end else if (start) begin
            m_state <= 1; m_pc <= start_addr; m_cnt <= 0;
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("running", running, m_state == 1);
            chk("halted", halted, m_state == 2);
            chk("count", count, m_cnt);
            chk("instr", instruction, (m_state == 1) ? rom[m_pc] : 8'h88);
        end
    end

    task automatic step(input bit st, input int addr, input bit bf, input bit bb,
                        input bit dn, input int off, input bit rn);
        @(negedge clk);
        start = st; start_addr = addr[9:0]; branchf = bf; branchb = bb;
        done = dn; offset = off[7:0]; reset_n = rn;
        @(posedge clk);
        #3;
    endtask

    task automatic idle_step();
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i) ^ 8'h5A;
        start = 1'b0; start_addr = 10'd0; branchf = 1'b0; branchb = 1'b0;
        done = 1'b0; offset = 8'd0; reset_n = 1'b0;

        do_reset();
        chk_en = 1'b1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, 32'h88);
        chk("rst_run", running, 32'h0);
        chk("rst_halt", halted, 32'h0);
        chk("rst_cnt", count, 32'h0);

        // 1: reset and start
        step(1'b1, 'h010, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("t1_pc0", pc, 32'h010);
        chk("t1_run", running, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            idle_step();
            chk("t1_pc", pc, 32'h010 + i);
            chk("t1_cnt", count, i);
        end

        // 2: forward, backward, both-high branches
        do_reset();
        step(1'b1, 'h020, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 5, 1'b1);
        chk("t2_fwd", pc, 32'h025);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 'h0A, 1'b1);
        chk("t2_bwd", pc, 32'h01B);
        step(1'b0, 0, 1'b1, 1'b1, 1'b0, 2, 1'b1);
        chk("t2_both", pc, 32'h01D);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        chk("t2_off0", pc, 32'h01D);

        // 3: wrap-around in both directions
        do_reset();
        step(1'b1, 'h3FF, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle_step();
        chk("t3_wrapup", pc, 32'h000);
        idle_step();
        idle_step();
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 4, 1'b1);
        chk("t3_wrapdn", pc, 32'h3FE);

        // 4: halt with a simultaneous branch, then restart
        do_reset();
        step(1'b1, 'h029, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 7; i++) idle_step();
        chk("t4_pc_pre", pc, 32'h030);
        chk("t4_cnt_pre", count, 32'd7);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1, 3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("t4_halted", halted, 32'h1);
            chk("t4_pc", pc, 32'h030);
            chk("t4_cnt", count, 32'd8);
            chk("t4_instr", instruction, 32'h88);
            step(1'b0, 0, 1'b1, 1'b1, 1'b1, 7, 1'b1);
        end
        step(1'b1, 'h100, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("t4_restart_pc", pc, 32'h100);
        chk("t4_restart_cnt", count, 32'd0);
        chk("t4_restart_run", running, 32'h1);

        // 5: ignored inputs in IDLE, start held in RUN, reset mid-run
        do_reset();
        step(1'b0, 0, 1'b1, 1'b0, 1'b1, 9, 1'b1);
        chk("t5_idle_pc", pc, 32'h0);
        chk("t5_idle_halt", halted, 32'h0);
        chk("t5_idle_run", running, 32'h0);
        step(1'b1, 'h04C, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 'h200, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("t5_seq_pc", pc, 32'h050);
        step(1'b1, 'h200, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("t5_rst_pc", pc, 32'h0);
        chk("t5_rst_run", running, 32'h0);
        chk("t5_rst_cnt", count, 32'h0);
        chk("t5_rst_instr", instruction, 32'h88);

        // 6: counter saturation
        do_reset();
        step(1'b1, 'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 20; i++) idle_step();
        chk("t6_sat", count, 32'hF);
        chk("t6_pc", pc, 32'd20);

        idle_step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
